// File: rtl/gl1_stream_framer.sv
// Transmit-side framer: tags a raw pixel stream with tuser (first pixel of frame)
// and tlast (last pixel of line); output register plus skid register on the way out.
module gl1_stream_framer #(
  parameter int D_WIDTH  = 8,
  parameter int H_PIXELS = 8,
  parameter int V_LINES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready,
  output logic               frame_done,
  output logic               busy
);
  // state | meaning
  // IDLE  | upstream blocked, counters parked at 0
  // RUN   | framing; leaves only on the last pixel of a frame with enable low

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_nxt;

  logic [XW-1:0]      x_cnt;
  logic [YW-1:0]      y_cnt;
  logic               skid_valid;
  logic [D_WIDTH-1:0] skid_data;
  logic               skid_tlast;
  logic               skid_tuser;
  logic               accept;
  logic               drain;
  logic               new_tuser;
  logic               new_tlast;
  logic               frame_last;

  // ready comes from registered state only, never from down_ready
  assign up_ready   = (state == RUN) && !skid_valid;
  assign accept     = up_valid && up_ready;
  assign drain      = down_valid && down_ready;
  assign new_tuser  = (x_cnt == '0) && (y_cnt == '0);
  assign new_tlast  = (x_cnt == X_LAST);
  assign frame_last = accept && new_tlast && (y_cnt == Y_LAST);
  assign busy       = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (frame_last && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= frame_last;
      if (state == IDLE) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (accept) begin
        if (new_tlast) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

  // skid can only be full while the output register is full, so an accept never
  // coincides with the skid-to-output move
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      down_tlast <= 1'b0;
      down_tuser <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tlast <= 1'b0;
      skid_tuser <= 1'b0;
    end else if (!down_valid || drain) begin
      if (skid_valid) begin
        down_valid <= 1'b1;
        down_data  <= skid_data;
        down_tlast <= skid_tlast;
        down_tuser <= skid_tuser;
        skid_valid <= 1'b0;
      end else if (accept) begin
        down_valid <= 1'b1;
        down_data  <= up_data;
        down_tlast <= new_tlast;
        down_tuser <= new_tuser;
      end else begin
        down_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= up_data;
      skid_tlast <= new_tlast;
      skid_tuser <= new_tuser;
    end
  end

endmodule

// File: tb/tb_gl1_stream_framer.sv
// Directed bench for gl1_stream_framer: a cycle table for the skid corner, then
// stream runs (H=4,V=2) checked against an occupancy model, plus an H=2,V=1 instance.
module tb_gl1_stream_framer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, up_valid, down_ready;
  logic [DW-1:0] up_data, down_data;
  logic          up_ready, down_valid, down_tlast, down_tuser, frame_done, busy;

  logic          en2, uv2, dr2, ur2, dv2, tl2, tu2, fd2, busy2;
  logic [DW-1:0] ud2, dd2;

  gl1_stream_framer #(.D_WIDTH(DW), .H_PIXELS(4), .V_LINES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_data(up_data), .up_valid(up_valid),
    .up_ready(up_ready), .down_data(down_data), .down_valid(down_valid),
    .down_tlast(down_tlast), .down_tuser(down_tuser), .down_ready(down_ready),
    .frame_done(frame_done), .busy(busy)
  );

  gl1_stream_framer #(.D_WIDTH(DW), .H_PIXELS(2), .V_LINES(1)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .up_data(ud2), .up_valid(uv2),
    .up_ready(ur2), .down_data(dd2), .down_valid(dv2),
    .down_tlast(tl2), .down_tuser(tu2), .down_ready(dr2),
    .frame_done(fd2), .busy(busy2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic          en, uv, dr;
    logic [DW-1:0] d;
    logic          e_ur, e_dv, e_busy, e_fd;
    logic [DW-1:0] e_d;
    logic          e_tl, e_tu;
  } vec_t;

  vec_t vecs[9];

  task automatic do_reset();
    enable = 1'b0; up_valid = 1'b0; down_ready = 1'b0; up_data = '0;
    en2 = 1'b0; uv2 = 1'b0; dr2 = 1'b0; ud2 = '0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Streams pixels first..last_pix into the H=4,V=2 instance starting from IDLE.
  task automatic run_stream(input int first, input int last_pix, input bit rand_dr,
                            input int drop_at, input string tag);
    int pix, rx, occ, cyc, first_acc, last_acc;
    bit run_m, exp_fd, acc, xfer, prev_stall, prev_tl, prev_tu;
    logic [DW-1:0] prev_d;
    pix = first; rx = first; occ = 0; cyc = 0; first_acc = -1; last_acc = -1;
    run_m = 1'b0; exp_fd = 1'b0; prev_stall = 1'b0; prev_tl = 1'b0; prev_tu = 1'b0;
    prev_d = '0;
    enable = 1'b1;
    while (rx <= last_pix && cyc < 500) begin
      chk({tag, " busy"}, busy, run_m);
      chk({tag, " up_ready"}, up_ready, run_m && occ < 2);
      chk({tag, " down_valid"}, down_valid, occ > 0);
      chk({tag, " frame_done"}, frame_done, exp_fd);
      if (prev_stall) begin
        chk({tag, " hold_valid"}, down_valid, 1);
        chk({tag, " hold_data"}, down_data, prev_d);
        chk({tag, " hold_tlast"}, down_tlast, prev_tl);
        chk({tag, " hold_tuser"}, down_tuser, prev_tu);
      end
      if (drop_at >= 0 && pix >= drop_at) enable = 1'b0;
      up_valid   = (pix <= last_pix);
      up_data    = pix[DW-1:0];
      down_ready = rand_dr ? 1'($urandom_range(0, 1)) : 1'b1;
      acc  = up_valid && up_ready;
      xfer = down_valid && down_ready;
      if (xfer) begin
        chk($sformatf("%s beat%0d data", tag, rx), down_data, rx % 256);
        chk($sformatf("%s beat%0d tuser", tag, rx), down_tuser, (rx % 8) == 0);
        chk($sformatf("%s beat%0d tlast", tag, rx), down_tlast, (rx % 4) == 3);
        rx++;
      end
      prev_stall = down_valid && !down_ready;
      prev_d = down_data; prev_tl = down_tlast; prev_tu = down_tuser;
      @(posedge clk); #1;
      cyc++;
      exp_fd = acc && ((pix % 8) == 7);
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        pix++;
      end
      occ = occ + int'(acc) - int'(xfer);
      if (!run_m && enable) run_m = 1'b1;
      else if (run_m && exp_fd && !enable) run_m = 1'b0;
    end
    up_valid = 1'b0;
    chk({tag, " completed"}, rx, last_pix + 1);
    if (!rand_dr) chk({tag, " throughput"}, last_acc - first_acc, last_pix - first);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, p, r;
    bit a, x, exp_fd2;

    //          en uv dr d       ur dv bsy fd e_d     tl tu
    vecs[0] = '{1, 1, 1, 8'h10, 0, 0, 0, 0, 8'h00, 0, 0};
    vecs[1] = '{1, 1, 0, 8'h10, 1, 0, 1, 0, 8'h00, 0, 0};
    vecs[2] = '{1, 1, 0, 8'h11, 1, 1, 1, 0, 8'h10, 0, 1};
    vecs[3] = '{1, 1, 0, 8'h12, 0, 1, 1, 0, 8'h10, 0, 1};
    vecs[4] = '{1, 1, 1, 8'h12, 0, 1, 1, 0, 8'h10, 0, 1};
    vecs[5] = '{1, 1, 1, 8'h12, 1, 1, 1, 0, 8'h11, 0, 0};
    vecs[6] = '{1, 1, 1, 8'h13, 1, 1, 1, 0, 8'h12, 0, 0};
    vecs[7] = '{1, 0, 1, 8'h00, 1, 1, 1, 0, 8'h13, 1, 0};
    vecs[8] = '{1, 0, 1, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0};

    rst = 1'b1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("vec%0d up_ready", i), up_ready, vecs[i].e_ur);
      chk($sformatf("vec%0d down_valid", i), down_valid, vecs[i].e_dv);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d frame_done", i), frame_done, vecs[i].e_fd);
      if (vecs[i].e_dv) begin
        chk($sformatf("vec%0d data", i), down_data, vecs[i].e_d);
        chk($sformatf("vec%0d tlast", i), down_tlast, vecs[i].e_tl);
        chk($sformatf("vec%0d tuser", i), down_tuser, vecs[i].e_tu);
      end
      enable = vecs[i].en; up_valid = vecs[i].uv;
      down_ready = vecs[i].dr; up_data = vecs[i].d;
      @(posedge clk); #1;
    end

    do_reset();
    run_stream(0, 15, 1'b0, -1, "full");

    do_reset();
    run_stream(0, 15, 1'b1, -1, "bp");

    do_reset();
    run_stream(0, 7, 1'b0, 3, "drop");
    enable = 1'b0; up_valid = 1'b1; up_data = 8'hAA; down_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d up_ready", i), up_ready, 0);
      chk($sformatf("hold%0d down_valid", i), down_valid, 0);
    end
    up_valid = 1'b0;
    run_stream(8, 15, 1'b0, -1, "resume");

    // stop mid-line at x=2, y=1 with a beat sitting in the output register
    do_reset();
    enable = 1'b1; up_valid = 1'b1; down_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 50) begin
      up_data = n[DW-1:0] + 8'h40;
      a = up_valid && up_ready;
      @(posedge clk); #1;
      cyc++;
      if (a) n++;
    end
    up_valid = 1'b0; down_ready = 1'b0;
    chk("midline accepted", n, 6);
    chk("pre_rst down_valid", down_valid, 1);
    #3 rst = 1'b0;
    #1;
    chk("async down_valid", down_valid, 0);
    chk("async down_data", down_data, 0);
    chk("async down_tlast", down_tlast, 0);
    chk("async down_tuser", down_tuser, 0);
    chk("async up_ready", up_ready, 0);
    chk("async frame_done", frame_done, 0);
    chk("async busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_stream(0, 7, 1'b0, -1, "post_rst");

    do_reset();
    en2 = 1'b1; dr2 = 1'b1;
    p = 0; r = 0; cyc = 0; exp_fd2 = 1'b0;
    while (r < 8 && cyc < 60) begin
      chk("h2 frame_done", fd2, exp_fd2);
      uv2 = (p < 8);
      ud2 = p[DW-1:0] + 8'h80;
      a = uv2 && ur2;
      x = dv2 && dr2;
      if (x) begin
        chk($sformatf("h2 beat%0d data", r), dd2, r + 128);
        chk($sformatf("h2 beat%0d tuser", r), tu2, (r % 2) == 0);
        chk($sformatf("h2 beat%0d tlast", r), tl2, (r % 2) == 1);
        r++;
      end
      @(posedge clk); #1;
      cyc++;
      exp_fd2 = a && ((p % 2) == 1);
      if (a) p++;
    end
    chk("h2 completed", r, 8);
    chk("h2 busy", busy2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gl1_stream_framer.md
# gl1_stream_framer

Transmit-side framer for the scenario-1 video stream. Takes an unframed pixel stream (data/valid/ready only) and emits a framed stream: down_tuser on the first pixel of every frame, down_tlast on the last pixel of every line. Frame geometry comes from parameters. It feeds the SOF-locking receiver stage, so downstream locks on the first down_tuser it sees. A registered, skid-buffered output gives full throughput with no combinational ready path from downstream to upstream.

## Interface
- D_WIDTH, 8, pixel data width
- H_PIXELS, 8, pixels per line (≥2)
- V_LINES, 4, lines per frame (≥1)

- clk  input  1  single clock, all logic rising-edge
- rst  input  1  asynchronous, active-low reset (asserted at rst=0)
- enable  input  1  framing enable; sampled only in IDLE and at frame boundaries
- up_data  input  D_WIDTH  raw pixel
- up_valid  input  1  raw pixel valid
- up_ready  output  1  framer accepts up_data this cycle
- down_data  output  D_WIDTH  framed pixel
- down_valid  output  1  framed pixel valid
- down_tlast  output  1  last pixel of line
- down_tuser  output  1  first pixel of frame (x=0, y=0)
- down_ready  input  1  downstream accepts
- frame_done  output  1  one-cycle pulse, last pixel of a frame accepted upstream
- busy  output  1  high in RUN

## Operation
- Upstream beat accepted when up_valid & up_ready. Downstream beat transfers when down_valid & down_ready.
- Counters: x_cnt (clog2(H_PIXELS) bits), y_cnt (clog2(V_LINES) bits, min 1). Both advance only on an upstream accept.
  - x wraps H_PIXELS-1→0 and increments y.
  - y wraps V_LINES-1→0.
- Sideband is computed from the counters at accept time and stored with the data:
  - tuser = (x==0 && y==0)
  - tlast = (x==H_PIXELS-1)
- FSM states:
  - IDLE: up_ready=0, counters held at 0. Goes to RUN when enable=1.
  - RUN: up_ready = !skid_valid.
    - Accept of the last pixel (x=H-1, y=V-1) with enable=1: stay RUN, counters wrap to 0.
    - Same accept with enable=0: go to IDLE.
    - enable deasserted mid-frame has no effect until that frame's last pixel.
- Output path is a 2-entry structure: output register (drives down_*) plus skid register.
  - Accept while the output register is empty, or is being drained this cycle: the beat goes to the output register.
  - Accept while the output register holds a stalled beat: the beat goes to skid.
  - When the output register drains and skid is valid: skid moves to the output register.
- Data and sideband stay together through both stages. Order is preserved. No beat is dropped or duplicated.
- frame_done: registered, high for exactly one cycle after the cycle in which the last pixel of a frame is accepted upstream.
- busy = (state==RUN).

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE; counters=0; output and skid registers invalid.
  - Outputs: down_valid=0, down_data=0, down_tlast=0, down_tuser=0, up_ready=0, frame_done=0, busy=0.
  - A partial frame in flight is discarded. After release the first emitted pixel carries tuser=1.
- Release: first RUN cycle is the cycle after the first rising edge with rst=1 and enable=1.
- Latency: upstream accept at edge N → down_valid=1 with that beat after edge N (1 cycle).
- Throughput: 1 pixel/clock when down_ready=1 continuously.
- Backpressure: when down_ready=0, at most one further beat is accepted (into skid). up_ready is then 0 from the next cycle. up_ready depends only on registered state.
- down_valid, once high, stays high with down_data/tlast/tuser stable until down_ready=1.
- Same-cycle accept and drain with skid empty: new beat goes straight to the output register, down_valid stays 1.
- Drain with skid valid: skid moves to the output register, up_ready returns to 1 next cycle.
- Upstream is never accepted in IDLE even if up_valid=1.

## Test plan
- H_PIXELS=4, V_LINES=2, enable=1, up_valid=1 and down_ready=1 constant, data 0..15:
  - down_valid one cycle after first accept.
  - tuser only on data 0 and 8.
  - tlast on 3, 7, 11, 15.
  - frame_done pulses after accepting 7 and 15.
  - Throughput 1/clk.
- Same config, down_ready toggled pseudo-randomly:
  - Output sequence identical to the previous case.
  - down_data stable while down_valid=1 and down_ready=0.
  - up_ready falls within one cycle of a stall.
- enable=1 then dropped at pixel 3 of frame 0:
  - Framer completes pixels 4..7, returns to IDLE (busy=0, up_ready=0) after accepting 7.
  - Re-asserting enable restarts with tuser on the next pixel.
- Hold enable=0 with up_valid=1 for 10 cycles: up_ready=0, down_valid=0 throughout.
- Assert rst=0 asynchronously mid-line (x=2, y=1) between clock edges:
  - All outputs 0 immediately.
  - After release, first output pixel has tuser=1, x restarts at 0.
- H_PIXELS=2, V_LINES=1: every frame is one line; each pixel pair is tuser,tlast; frame_done every second accept.
